// File: rtl/fetch_queue_if.sv
// Handshake bundle between the fetch queue, instruction memory and decode.
// The master side is the fetch queue itself.
interface fetch_queue_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_rdata;
  logic          inst_valid;
  logic [DW-1:0] inst_data;
  logic [AW-1:0] inst_pc;
  logic          inst_ready;

  modport master (
    output imem_req, imem_addr, inst_valid, inst_data, inst_pc,
    input  imem_rdata, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_data, inst_pc,
    output imem_rdata, inst_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch queue: issues imem reads at p_ct, tracks them across the
// fixed memory latency and buffers returned words for decode.
module fetch_queue #(
  parameter int AW      = 10,
  parameter int DW      = 32,
  parameter int DEPTH   = 4,
  parameter int MEM_LAT = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [AW-1:0]              p_ct,
  input  logic                       branch_enable,
  output logic                       pc_hold,
  output logic [$clog2(DEPTH+1)-1:0] fq_count,
  fetch_queue_if.master              bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int LW = $clog2(MEM_LAT + 1);
  localparam int SW = $clog2(DEPTH + MEM_LAT + 1);

  logic [MEM_LAT-1:0] trk_vld_q, trk_vld_d;
  logic [AW-1:0]      trk_pc_q [MEM_LAT];
  logic [AW-1:0]      trk_pc_d [MEM_LAT];
  logic [DW-1:0]      fifo_data_q [DEPTH];
  logic [DW-1:0]      fifo_data_d [DEPTH];
  logic [AW-1:0]      fifo_pc_q [DEPTH];
  logic [AW-1:0]      fifo_pc_d [DEPTH];
  logic [PW:0]        wr_ptr_q, wr_ptr_d;
  logic [PW:0]        rd_ptr_q, rd_ptr_d;

  logic [LW-1:0] inflight;
  logic [SW-1:0] credit;
  logic          empty;
  logic          push;
  logic          pop;

  // Credit is built from registered state only, so a pop in the current
  // cycle does not free a slot until the next one.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < MEM_LAT; i++) begin
      inflight = inflight + LW'(trk_vld_q[i]);
    end
    fq_count = CW'(wr_ptr_q - rd_ptr_q);
    credit   = SW'(fq_count) + SW'(inflight);
    pc_hold  = credit >= SW'(DEPTH);
    empty    = wr_ptr_q == rd_ptr_q;
    push     = trk_vld_q[MEM_LAT-1] && !branch_enable;
    pop      = !empty && bus.inst_ready && !branch_enable;
  end

  assign bus.imem_req   = reset && !pc_hold && !branch_enable;
  assign bus.imem_addr  = p_ct;
  assign bus.inst_valid = !empty;
  assign bus.inst_data  = fifo_data_q[rd_ptr_q[PW-1:0]];
  assign bus.inst_pc    = fifo_pc_q[rd_ptr_q[PW-1:0]];

  always_comb begin
    trk_vld_d   = MEM_LAT'({trk_vld_q, bus.imem_req});
    trk_pc_d    = trk_pc_q;
    trk_pc_d[0] = p_ct;
    for (int i = 1; i < MEM_LAT; i++) begin
      trk_pc_d[i] = trk_pc_q[i-1];
    end
    if (branch_enable) begin
      trk_vld_d = '0;
    end
  end

  always_comb begin
    fifo_data_d = fifo_data_q;
    fifo_pc_d   = fifo_pc_q;
    if (push) begin
      fifo_data_d[wr_ptr_q[PW-1:0]] = bus.imem_rdata;
      fifo_pc_d[wr_ptr_q[PW-1:0]]   = trk_pc_q[MEM_LAT-1];
    end
    wr_ptr_d = wr_ptr_q + (PW+1)'(push);
    rd_ptr_d = rd_ptr_q + (PW+1)'(pop);
    if (branch_enable) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trk_vld_q   <= '0;
      trk_pc_q    <= '{default: '0};
      fifo_data_q <= '{default: '0};
      fifo_pc_q   <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      trk_vld_q   <= trk_vld_d;
      trk_pc_q    <= trk_pc_d;
      fifo_data_q <= fifo_data_d;
      fifo_pc_q   <= fifo_pc_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

endmodule
